// File: rtl/spi_flash_pkg.sv
// Shared constants, state encoding and byte-order helper for the SPI flash read controller.
// Imported by the controller top and its SCK generator.
package spi_flash_pkg;

    localparam logic [7:0] CMD_READ     = 8'h03;
    localparam int         CMD_BITS     = 8;
    localparam int         ADDR_BITS    = 24;
    localparam int         DATA_BITS    = 32;
    localparam int         SCK_PERIODS  = 63;
    localparam int         FIRST_SAMPLE = 31;
    localparam int         PERIOD_W     = 6;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP,
        RESP
    } state_t;

    // Flash bytes arrive addr+0 first, so the first byte received is the low byte of the word.
    function automatic logic [DATA_BITS-1:0] bswap32(input logic [DATA_BITS-1:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// Mode-0 SCK generator: DIV-clock low half then DIV-clock high half, SCK_PERIODS periods while enabled.
// rise_o/fall_o flag the cycle whose closing edge moves sck; done_o marks the final fall.
module spi_sck_gen
    import spi_flash_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable_i,
    output logic                sck_o,
    output logic                rise_o,
    output logic                fall_o,
    output logic                done_o,
    output logic [PERIOD_W-1:0] period_o
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0]    cnt_q;
    logic                sck_q;
    logic [PERIOD_W-1:0] period_q;
    logic                half_end;

    assign half_end = enable_i && (cnt_q == CNT_W'(DIV - 1));
    assign rise_o   = half_end && !sck_q;
    assign fall_o   = half_end && sck_q;
    assign done_o   = fall_o && (period_q == PERIOD_W'(SCK_PERIODS - 1));
    assign sck_o    = sck_q;
    assign period_o = period_q;

    // Counters are held at zero while disabled so each burst starts with a full low half.
    always_ff @(posedge clock) begin
        if (reset || !enable_i) begin
            cnt_q    <= '0;
            sck_q    <= 1'b0;
            period_q <= '0;
        end else if (half_end) begin
            cnt_q <= '0;
            sck_q <= !sck_q;
            if (sck_q) begin
                period_q <= done_o ? '0 : period_q + 1'b1;
            end
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/spi_flash_read_ctrl.sv
// Turns single-word bus reads into 03h serial-NOR read bursts and returns a little-endian word.
// One request outstanding; req_ready only in IDLE, response held until resp_ready.
module spi_flash_read_ctrl
    import spi_flash_pkg::*;
#(
    parameter int DIV     = 2,
    parameter int CS_IDLE = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_BITS-1:0] req_addr,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [DATA_BITS-1:0] resp_data,
    output logic                 resp_err,
    output logic                 busy,
    output logic                 spi_sck,
    output logic                 spi_ss,
    output logic                 spi_mosi,
    input  logic                 spi_miso
);

    localparam int GAP_W = (CS_IDLE > 1) ? $clog2(CS_IDLE) : 1;

    state_t                 state_q;
    logic [DATA_BITS-1:0]   tx_q;
    logic [DATA_BITS-1:0]   rx_q;
    logic [DATA_BITS-1:0]   resp_data_q;
    logic [GAP_W-1:0]       gap_q;
    logic                   ss_q;
    logic                   mosi_q;
    logic                   resp_valid_q;
    logic                   resp_err_q;

    logic                   sck_fall;
    logic                   sck_done;
    logic                   unused_sck_rise;
    logic [PERIOD_W-1:0]    period;

    spi_sck_gen #(
        .DIV(DIV)
    ) u_sck_gen (
        .clock    (clock),
        .reset    (reset),
        .enable_i (state_q == SHIFT),
        .sck_o    (spi_sck),
        .rise_o   (unused_sck_rise),
        .fall_o   (sck_fall),
        .done_o   (sck_done),
        .period_o (period)
    );

    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign spi_ss     = ss_q;
    assign spi_mosi   = mosi_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            tx_q         <= '0;
            rx_q         <= '0;
            resp_data_q  <= '0;
            gap_q        <= '0;
            ss_q         <= 1'b1;
            mosi_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        if (req_addr[1:0] != 2'b00) begin
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_data_q  <= '0;
                            state_q      <= RESP;
                        end else begin
                            tx_q    <= {CMD_READ, req_addr};
                            mosi_q  <= CMD_READ[CMD_BITS-1];
                            ss_q    <= 1'b0;
                            state_q <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    // mosi and miso both move on the sck falling edge; the last command bit is period 31.
                    if (sck_fall) begin
                        tx_q   <= {tx_q[DATA_BITS-2:0], 1'b0};
                        mosi_q <= (period < PERIOD_W'(FIRST_SAMPLE)) ? tx_q[DATA_BITS-2] : 1'b0;
                        if (period >= PERIOD_W'(FIRST_SAMPLE)) begin
                            rx_q <= {rx_q[DATA_BITS-2:0], spi_miso};
                        end
                    end
                    if (sck_done) begin
                        ss_q    <= 1'b1;
                        mosi_q  <= 1'b0;
                        gap_q   <= '0;
                        state_q <= GAP;
                    end
                end
                GAP: begin
                    if (gap_q == GAP_W'(CS_IDLE - 1)) begin
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_data_q  <= bswap32(rx_q);
                        state_q      <= RESP;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/spi_flash_read_ctrl.md
Name: spi_flash_read_ctrl

Overview:
- SPI master that turns single-word read requests from the on-chip bus side into serial-NOR `03h` read transactions on the flash pins (sck/ss/mosi/miso).
- Sits between the bus bridge and the SPI flash device.
- Sequences command, address and data phases, divides the SPI clock from the system clock, and returns one little-endian 32-bit word per request via valid/ready handshakes.

Parameters:
- DIV, 2, SCK half-period in system clocks (>=1); SCK period = 2*DIV clocks.
- CS_IDLE, 2, minimum system clocks ss stays high between transactions (>=1).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  read request valid
- req_ready  out  1  controller can accept a request (high only in IDLE)
- req_addr  in  24  flash byte address
- resp_valid  out  1  response valid, held until resp_ready
- resp_ready  in  1  consumer accepts response
- resp_data  out  32  read word, little-endian (byte at addr in [7:0])
- resp_err  out  1  request rejected (misaligned); resp_data=0
- busy  out  1  high in any state other than IDLE
- spi_sck  out  1  SPI clock, idles low (mode 0)
- spi_ss  out  1  chip select, active low, idles high
- spi_mosi  out  1  serial out, MSB first
- spi_miso  in  1  serial in, MSB first

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high. Clock port is `clock`, reset port is `reset`.
- Reset values: spi_ss=1, spi_sck=0, spi_mosi=0, resp_valid=0, resp_err=0, resp_data=0, busy=0. State is IDLE.
- Reset mid-transaction: ss rises on the next edge and any pending response is dropped.
- States: IDLE, SHIFT, GAP, RESP.
- IDLE:
  - req_ready=1. A handshake occurs at edge E0 when req_valid&&req_ready.
  - If req_addr[1:0]!=0: go to RESP with resp_err=1 and resp_data=0. No SPI activity.
  - Otherwise: load tx shift = {8'h03, req_addr} (32 bits), drive ss=0, drive mosi=tx[31], clear the bit counter, and enter SHIFT.
- SHIFT timing:
  - 63 SCK periods. Each period is a low half of DIV clocks, then sck rises, then a high half of DIV clocks, then sck falls.
  - The divider counter runs only in SHIFT.
- SHIFT, periods 0..31:
  - mosi carries tx MSB-first.
  - tx shifts left, and mosi updates on the same clock that sck falls.
  - mosi is therefore stable across each rising edge.
- SHIFT, periods 31..62:
  - miso is sampled on the clock at which sck falls: rx = {rx[30:0], miso}.
  - The first sample (period 31) is data bit 31; 32 samples total.
  - mosi is driven 0 after period 31.
- SHIFT exit: after the fall of period 62, drive ss=1 and sck=0, then enter GAP.
- Byte order: resp_data = {rx[7:0], rx[15:8], rx[23:16], rx[31:24]}. Flash bytes arrive addr+0 first.
- GAP: wait exactly CS_IDLE clocks with ss=1, then go to RESP with resp_data loaded and resp_err=0.
- RESP:
  - resp_valid=1. resp_data and resp_err stay stable until resp_ready.
  - On resp_valid&&resp_ready, go to IDLE. req_ready rises the following cycle; there is no same-cycle accept.
- Latency: resp_valid first high 126*DIV + CS_IDLE + 1 clocks after E0 (DIV=2, CS_IDLE=2 gives 255). Error responses: 1 clock after E0.
- Invariants:
  - sck toggles only while ss=0.
  - ss is never low in IDLE/GAP/RESP.
  - Exactly 63 rising sck edges per transaction.
  - Only one request is outstanding at a time.
- Boundaries:
  - req_addr=24'hFFFFFC is legal (no wrap checking; the device wraps).
  - resp_ready held low stalls in RESP indefinitely.
  - req_valid while busy is ignored (not queued).

Decomposition:
- Package spi_flash_pkg:
  - CMD_READ=8'h03, CMD_BITS=8, ADDR_BITS=24, DATA_BITS=32.
  - SCK_PERIODS=63, FIRST_SAMPLE=31.
  - state_t enum {IDLE, SHIFT, GAP, RESP}.
- Sub-module spi_sck_gen (parameter DIV):
  - Inputs: enable, clock, reset.
  - Outputs: sck level, a rise strobe and a fall strobe (one clock each), and a period index 0..62.
  - Asserts done after the fall of period 62.

Test Plan:
- Flash model preloaded with bytes 11 22 33 44 at 0x000100; request 0x000100 -> resp_data=32'h44332211, resp_err=0, latency 255 clocks (DIV=2, CS_IDLE=2).
- Same read: capture mosi at each sck rise -> bitstream 0x03 then 0x000100 MSB-first; exactly 63 rises; ss low for whole burst.
- Request 0x000102 -> resp_valid after 1 clock with resp_err=1 and resp_data=0; ss/sck never toggle.
- Back-to-back requests to 0x0 and 0x4 with resp_ready=1 -> two correct words; ss high >= CS_IDLE clocks between bursts; second req_ready rises one clock after first response handshake.
- Hold resp_ready=0 for 20 clocks after resp_valid -> resp_valid/resp_data stable, req_ready=0, busy=1; then accept.
- Assert reset at period 40 of SHIFT -> next clock ss=1, sck=0, busy=0, no resp_valid; a fresh request afterwards returns correct data.
